// File: rtl/updown_pkg.sv
// updown_pkg: shared encodings for the updown counter and its sweep sequencer
package updown_pkg;
    localparam int   DEF_W   = 4;
    localparam logic CTRL_UP = 1'b1;
    localparam logic CTRL_DN = 1'b0;
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        UP   = 3'd2,
        DOWN = 3'd3,
        DONE = 3'd4
    } state_t;
endpackage

// File: rtl/updown.sv
// updown: loadable up/down counter that steps every clock unless loaded
module updown
    import updown_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic         clk,
    input  logic         load,
    input  logic [W-1:0] data_in,
    input  logic         control,
    output logic [W-1:0] count
);
    // load wins, otherwise count one step in the commanded direction
    always_ff @(posedge clk)
        count <= load ? data_in : (control == CTRL_UP ? count + 1'b1 : count - 1'b1);
endmodule

// File: rtl/updown_sweep_ctrl.sv
// updown_sweep_ctrl: drives an updown counter through n lo->hi->lo sweeps
module updown_sweep_ctrl
    import updown_pkg::*;
#(
    parameter int W = DEF_W,
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    input  logic [W-1:0] lo,
    input  logic [W-1:0] hi,
    input  logic [N-1:0] n_sweeps,
    input  logic [W-1:0] count,
    output logic         ctr_load,
    output logic [W-1:0] ctr_data,
    output logic         ctr_control,
    output logic         busy,
    output logic         done,
    output logic         err
);
    state_t       state, state_nx;
    logic [W-1:0] lo_q, hi_q;
    logic [N-1:0] n_q, sweeps;
    logic         done_q, err_q;
    logic         idle_start, range_ok, accept, top_hit, bot_hit, last;

    assign idle_start = state == IDLE && start;
    assign range_ok   = hi > lo;
    assign accept     = idle_start && range_ok && n_sweeps != '0;
    // reversal is decided one count early so the counter never overshoots a bound
    assign top_hit    = count == hi_q - 1'b1;
    assign bot_hit    = count == lo_q + 1'b1;
    assign last       = sweeps + 1'b1 == n_q;

    assign busy        = state == LOAD || state == UP || state == DOWN;
    assign ctr_load    = !(state == UP || state == DOWN);
    assign ctr_data    = lo_q;
    assign ctr_control = state == UP ? CTRL_UP : CTRL_DN;
    assign done        = state == DONE || done_q;
    assign err         = err_q;

    // state register, request latches, sweep counter and one-cycle status pulses
    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            lo_q   <= '0;
            hi_q   <= '0;
            n_q    <= '0;
            sweeps <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_nx;
            done_q <= idle_start && range_ok && n_sweeps == '0;
            err_q  <= idle_start && !range_ok;
            if (idle_start && range_ok)
                lo_q <= lo;
            if (accept) begin
                hi_q   <= hi;
                n_q    <= n_sweeps;
                sweeps <= '0;
            end else if (state == DOWN && bot_hit && !abort) begin
                sweeps <= sweeps + 1'b1;
            end
        end
    end

    // next state; abort overrides any transition while busy
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = LOAD;
            LOAD:    state_nx = UP;
            UP:      if (top_hit) state_nx = DOWN;
            DOWN:    if (bot_hit) state_nx = last ? DONE : UP;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (abort && busy)
            state_nx = IDLE;
    end
endmodule
